// File: rtl/ppi_mode1_handshake.sv
// Strobed-handshake (8255 mode 1) controller for one PPI port group (A or B).
// Define PPI_OVERRUN_FLAG_EN to add the sticky overrun status output.
module ppi_mode1_handshake #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_OUT     = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       mode1_en,
  input  logic       dir_in,
  input  logic       inte,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       port_oe,
  input  logic       stb_n,
  input  logic       ack_n,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr
`ifdef PPI_OVERRUN_FLAG_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [1:0] {IDLE, IN_FULL, OUT_FULL, OUT_ACK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [7:0]             pin_sync [SYNC_STAGES];
  logic                   stb_d;
  logic                   ack_d;
  logic [7:0]             in_latch;
  logic                   intr_req;
  logic                   mode_q;
  logic                   dir_q;

  logic                   stb_s;
  logic                   ack_s;
  logic [7:0]             pin_s;
  logic                   stb_fall;
  logic                   stb_rise;
  logic                   ack_fall;
  logic                   ack_rise;
  logic                   cfg_chg;

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign pin_s    = pin_sync[SYNC_STAGES-1];
  assign stb_fall = stb_d & ~stb_s;
  assign stb_rise = ~stb_d & stb_s;
  assign ack_fall = ack_d & ~ack_s;
  assign ack_rise = ~ack_d & ack_s;
  assign cfg_chg  = (mode1_en != mode_q) | (dir_in != dir_q);

  assign port_oe  = ~dir_in;
  // inte only masks the request; intr_req itself is untouched by it
  assign intr     = intr_req & inte & mode1_en;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stb_sync <= '1;
      ack_sync <= '1;
      stb_d    <= 1'b1;
      ack_d    <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) pin_sync[i] <= 8'h00;
    end else begin
      stb_sync    <= {stb_sync[SYNC_STAGES-2:0], stb_n};
      ack_sync    <= {ack_sync[SYNC_STAGES-2:0], ack_n};
      stb_d       <= stb_s;
      ack_d       <= ack_s;
      pin_sync[0] <= port_in;
      for (int i = 1; i < SYNC_STAGES; i++) pin_sync[i] <= pin_sync[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      in_latch <= 8'h00;
      port_out <= RST_OUT;
      ibf      <= 1'b0;
      obf_n    <= 1'b1;
      intr_req <= 1'b0;
      mode_q   <= mode1_en;
      dir_q    <= dir_in;
`ifdef PPI_OVERRUN_FLAG_EN
      overrun  <= 1'b0;
`endif
    end else begin
      mode_q <= mode1_en;
      dir_q  <= dir_in;
      if (cpu_wr) port_out <= cpu_wdata;

      // Mode 0 and any reconfiguration park the handshake; latches are kept
      if (!mode1_en || cfg_chg) begin
        state    <= IDLE;
        ibf      <= 1'b0;
        obf_n    <= 1'b1;
        intr_req <= 1'b0;
`ifdef PPI_OVERRUN_FLAG_EN
        overrun  <= 1'b0;
`endif
      end else if (dir_in) begin
        // A strobe beats a coincident read: new data lands, ibf stays set
        if (stb_fall) begin
          in_latch <= pin_s;
          ibf      <= 1'b1;
          state    <= IN_FULL;
          if (cpu_rd) intr_req <= 1'b0;
        end else if (cpu_rd) begin
          ibf      <= 1'b0;
          intr_req <= 1'b0;
          state    <= IDLE;
        end else if (stb_rise && ibf) begin
          intr_req <= 1'b1;
        end
`ifdef PPI_OVERRUN_FLAG_EN
        if (stb_fall && ibf) overrun <= 1'b1;
        else if (cpu_rd)     overrun <= 1'b0;
`endif
      end else begin
        if (cpu_wr) begin
          obf_n    <= 1'b0;
          intr_req <= 1'b0;
          state    <= OUT_FULL;
        end else if (ack_fall && state == OUT_FULL) begin
          obf_n <= 1'b1;
          state <= OUT_ACK;
        end else if (ack_rise && state == OUT_ACK) begin
          intr_req <= 1'b1;
          state    <= IDLE;
        end
`ifdef PPI_OVERRUN_FLAG_EN
        if (cpu_wr) overrun <= ~obf_n;
`endif
      end
    end
  end

  always_comb begin
    cpu_rdata = port_out;
    if (dir_in) cpu_rdata = mode1_en ? in_latch : pin_s;
  end

endmodule
